arb_mux2_rr: RTL
================

Name: arb_mux2_rr

Overview:
- Two-input round-robin arbiter with a registered output stage. It sits directly upstream of the team's 2:1 mux datapath.
- It takes two valid/ready streams and picks one word per cycle. The chosen word goes into a single output register.
- It presents the registered data together with a select bit that names the source, using mux convention: sel=0 is input a, sel=1 is input b.
- Downstream logic consumes the word over a valid/ready handshake.

Parameters:
- WIDTH, 8, data width of each input and of the output.
- FIRST_PRIO, 0, input that wins the first contested cycle after reset (0=a, 1=b).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  input a holds a word.
- a_data  input  WIDTH  input a word.
- a_ready  output  1  input a word accepted this cycle.
- b_valid  input  1  input b holds a word.
- b_data  input  WIDTH  input b word.
- b_ready  output  1  input b word accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_sel  output  1  source of out_data (0=a, 1=b).
- out_ready  input  1  downstream accepts out_data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0, state=EMPTY, priority pointer=FIRST_PRIO.
  - a_ready and b_ready are 0 while rst_n=0.
- Output register state machine:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - EMPTY to FULL when a grant occurs.
  - FULL to EMPTY when out_ready=1 and there is no new grant.
  - FULL stays FULL on drain plus a simultaneous grant (new word loaded), or while out_ready=0.
- Capacity: can_load = (state==EMPTY) or out_ready. Combinational ready paths exist only from out_ready.
- Grant rules (evaluated only when can_load=1):
  - Only a_valid: grant a.
  - Only b_valid: grant b.
  - Both valid: grant the input named by the priority pointer.
  - After any grant the pointer moves to the other input. An uncontested grant also flips the pointer.
  - When can_load=0 there is no grant and the pointer holds.
- a_ready = can_load and grant==a. b_ready = can_load and grant==b. At most one is 1 per cycle.
- A valid input may be stalled indefinitely; it does not drop its word.
- Load: on the grant edge, out_data takes the granted data and out_sel takes the granted index. Latency is 1 cycle from input handshake to out_valid.
- Hold: while out_valid=1 and out_ready=0, out_data and out_sel are stable.
- Throughput: 1 word/cycle when out_ready is held at 1.
- Reset mid-transfer: the held word is discarded, the pointer returns to FIRST_PRIO, and no handshake completes in that cycle.
- out_data is not cleared on drain. It is only meaningful while out_valid=1.

Optional Feature:
- Macro: ARB_MUX2_STATS_EN.
- When defined, adds two outputs:
  - cnt_a  output 16: count of a-handshakes, saturating at 16'hFFFF.
  - cnt_b  output 16: count of b-handshakes, saturating at 16'hFFFF.
  - Both counters reset to 0 on rst_n=0 and increment on the same edge as the handshake.
- When not defined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Reset check: drive rst_n=0 mid-simulation with out_valid=1 -> out_valid=0, out_sel=0, a_ready=b_ready=0 immediately, without waiting for clk.
- Single source: a_valid=1, a_data=8'h5A, b_valid=0, out_ready=1 -> a_ready=1; next cycle out_valid=1, out_data=8'h5A, out_sel=0.
- Contention with FIRST_PRIO=0: a=8'h11 and b=8'h22 both valid continuously, out_ready=1 -> outputs 11,22,11,22 with out_sel 0,1,0,1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and both inputs valid -> a_ready=b_ready=0 and out_data stable. When out_ready rises, the pending grant loads on the same edge as the drain and out_valid stays 1.
- Pointer flip: grant b alone (b=8'h33), then a and b both valid -> a wins next (pointer moved to a).
- Stats, with ARB_MUX2_STATS_EN defined: 5 a-handshakes and 3 b-handshakes -> cnt_a=5, cnt_b=3. Force 70000 a-handshakes -> cnt_a=16'hFFFF.

Source files
------------

// File: rtl/arb_mux2_rr.sv
// arb_mux2_rr: two-input round-robin arbiter feeding a single output register.
// The output stage presents the registered word with a mux-style select bit
// (0 = input a, 1 = input b) and drains over a valid/ready handshake.
// Optional handshake counters are enabled by defining ARB_MUX2_STATS_EN.
module arb_mux2_rr #(
  parameter int   WIDTH      = 8,
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
`ifdef ARB_MUX2_STATS_EN
  ,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;

  logic can_load;
  logic grant_a;
  logic grant_b;

  // Arbitration, ready generation and next-state for the output register.
  // Readies are gated by rst_n so no handshake can complete while in reset.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    sel_d    = sel_q;
    can_load = (state_q == EMPTY) || out_ready;
    grant_a  = rst_n && can_load && a_valid && (!b_valid || !ptr_q);
    grant_b  = rst_n && can_load && b_valid && (!a_valid ||  ptr_q);

    if (grant_a || grant_b) begin
      data_d  = grant_b ? b_data : a_data;
      sel_d   = grant_b;
      // Pointer always names the input that did not just win.
      ptr_d   = !grant_b;
      state_d = FULL;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Output register, state and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= FIRST_PRIO;
      data_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

`ifdef ARB_MUX2_STATS_EN
  logic [15:0] cnt_a_q, cnt_a_d;
  logic [15:0] cnt_b_q, cnt_b_d;

  // Saturating handshake counters.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (grant_a && cnt_a_q != 16'hFFFF) cnt_a_d = cnt_a_q + 16'd1;
    if (grant_b && cnt_b_q != 16'hFFFF) cnt_b_d = cnt_b_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule
